ahb_apb_top: RTL and testbench

AHB_APB_TOP -- requirements
Module: ahb_apb_top

---
 rtl/ahb_apb_top.sv | 186 ++++++++++++++++++
 tb/tb_ahb_apb_top.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_apb_top.sv
// ahb_apb_top: AHB-to-APB bridge with three APB slaves decoded from the top address bits.
//
// Ports
//   hclk       : clock, all state updates on the rising edge
//   hresetn    : synchronous reset, ACTIVE HIGH despite the name
//   hwrite     : AHB direction (1 = write)
//   hreadyin   : AHB ready into the bridge
//   htrans     : AHB transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
//   haddr      : AHB address
//   hwdata     : AHB write data
//   prdata     : APB read data
//   hrdata     : AHB read data, a straight combinational copy of prdata
//   hresp      : AHB response, always OKAY
//   hreadyout  : AHB ready out, registered
//   pwrite     : APB direction, registered
//   penable    : APB enable, registered
//   pselx      : one-hot APB select (001/010/100), registered
//   pwdata     : APB write data, registered
//   paddr      : APB address, registered
//
// Address map: 0x8000_0000-0x83FF_FFFF slave 0, 0x8400_0000-0x87FF_FFFF slave 1,
// 0x8800_0000-0x8BFF_FFFF slave 2. Anything else is ignored.
module ahb_apb_top (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hwrite,
  input  logic        hreadyin,
  input  logic [1:0]  htrans,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  input  logic [31:0] prdata,
  output logic [31:0] hrdata,
  output logic [1:0]  hresp,
  output logic        hreadyout,
  output logic        pwrite,
  output logic        penable,
  output logic [2:0]  pselx,
  output logic [31:0] pwdata,
  output logic [31:0] paddr
);

  localparam logic [31:0] S0_BASE = 32'h8000_0000;
  localparam logic [31:0] S1_BASE = 32'h8400_0000;
  localparam logic [31:0] S2_BASE = 32'h8800_0000;
  localparam logic [31:0] S2_LAST = 32'h8BFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WWAIT, ST_WRITE, ST_WRITEP,
    ST_WENABLE, ST_WENABLEP, ST_READ, ST_RENABLE
  } state_t;

  state_t      state;
  logic [31:0] haddr1, haddr2, hwdata1, hwdata2;
  logic        hwrite_reg;
  logic        valid;
  logic [2:0]  tempselx;

  function automatic logic [2:0] decode(input logic [31:0] a);
    if (a >= S0_BASE && a < S1_BASE)       decode = 3'b001;
    else if (a >= S1_BASE && a < S2_BASE)  decode = 3'b010;
    else if (a >= S2_BASE && a <= S2_LAST) decode = 3'b100;
    else                                   decode = 3'b000;
  endfunction

  // ---------------------------------------------------------------------------
  // AHB slave side: input pipeline, transfer qualification, slave decode
  // ---------------------------------------------------------------------------
  always_ff @(posedge hclk) begin
    if (hresetn) begin
      haddr1     <= '0;
      haddr2     <= '0;
      hwdata1    <= '0;
      hwdata2    <= '0;
      hwrite_reg <= 1'b0;
    end else begin
      haddr1     <= haddr;
      haddr2     <= haddr1;
      hwdata1    <= hwdata;
      hwdata2    <= hwdata1;
      hwrite_reg <= hwrite;
    end
  end

  // Only NONSEQ/SEQ transfers inside the bridge window are acted on.
  assign valid    = hreadyin && (htrans == 2'b10 || htrans == 2'b11) &&
                    (haddr >= S0_BASE) && (haddr <= S2_LAST);
  assign tempselx = decode(haddr);

  assign hrdata = prdata;
  assign hresp  = 2'b00;

  // ---------------------------------------------------------------------------
  // APB controller. Every branch loads the outputs that belong to the state
  // being entered, so the outputs are registered and line up with that state.
  //
  // Write address source: the address phase of the write being launched sits
  // in haddr1 when coming straight out of WWAIT, but one stage further back
  // (haddr2) when chaining from WENABLEP, because an extra cycle has elapsed.
  // pselx for a write is decoded from that same registered address rather
  // than from the live haddr, which by then already carries the next transfer.
  // ---------------------------------------------------------------------------
  always_ff @(posedge hclk) begin
    if (hresetn) begin
      state     <= ST_IDLE;
      paddr     <= '0;
      pwdata    <= '0;
      pwrite    <= 1'b0;
      penable   <= 1'b0;
      pselx     <= 3'b000;
      hreadyout <= 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_RENABLE, ST_WENABLE: begin
          if (valid && !hwrite) begin
            state     <= ST_READ;
            paddr     <= haddr;
            pwrite    <= 1'b0;
            pselx     <= tempselx;
            penable   <= 1'b0;
            hreadyout <= 1'b0;
          end else begin
            // A write first waits one cycle in WWAIT for its data phase.
            state     <= valid ? ST_WWAIT : ST_IDLE;
            pselx     <= 3'b000;
            penable   <= 1'b0;
            hreadyout <= 1'b1;
          end
        end

        ST_WWAIT: begin
          state     <= valid ? ST_WRITEP : ST_WRITE;
          paddr     <= haddr1;
          pwdata    <= hwdata;
          pwrite    <= 1'b1;
          pselx     <= decode(haddr1);
          penable   <= 1'b0;
          hreadyout <= 1'b0;
        end

        ST_WRITE: begin
          state     <= valid ? ST_WENABLEP : ST_WENABLE;
          penable   <= 1'b1;
          hreadyout <= 1'b1;
        end

        ST_WRITEP: begin
          state     <= ST_WENABLEP;
          penable   <= 1'b1;
          hreadyout <= 1'b1;
        end

        ST_WENABLEP: begin
          if (!hwrite_reg) begin
            // Pending transfer is a read: launch it directly.
            state     <= ST_READ;
            paddr     <= haddr;
            pwrite    <= 1'b0;
            pselx     <= tempselx;
            penable   <= 1'b0;
            hreadyout <= 1'b0;
          end else begin
            state     <= valid ? ST_WRITEP : ST_WRITE;
            paddr     <= haddr2;
            pwdata    <= hwdata;
            pwrite    <= 1'b1;
            pselx     <= decode(haddr2);
            penable   <= 1'b0;
            hreadyout <= 1'b0;
          end
        end

        ST_READ: begin
          state     <= ST_RENABLE;
          penable   <= 1'b1;
          hreadyout <= 1'b1;
        end
      endcase
    end
  end

  // hwdata1/hwdata2 are kept as part of the input pipeline; the write data
  // itself is taken from the live data phase.
  logic unused_ok;
  assign unused_ok = ^{hwdata2};

endmodule

// File: tb/tb_ahb_apb_top.sv
// Directed bench for ahb_apb_top: reset, single write, single read, 4-beat
// write burst, ignored transfers and decode boundaries, write followed by
// read, and reset in the middle of a transfer.
module tb_ahb_apb_top;

  logic        hclk = 1'b0;
  logic        hresetn, hwrite, hreadyin;
  logic [1:0]  htrans;
  logic [31:0] haddr, hwdata, prdata;
  logic [31:0] hrdata, pwdata, paddr;
  logic [1:0]  hresp;
  logic        hreadyout, pwrite, penable;
  logic [2:0]  pselx;

  int npass = 0;
  int ntot  = 0;

  ahb_apb_top dut (
    .hclk(hclk), .hresetn(hresetn), .hwrite(hwrite), .hreadyin(hreadyin),
    .htrans(htrans), .haddr(haddr), .hwdata(hwdata), .prdata(prdata),
    .hrdata(hrdata), .hresp(hresp), .hreadyout(hreadyout), .pwrite(pwrite),
    .penable(penable), .pselx(pselx), .pwdata(pwdata), .paddr(paddr)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge hclk);
    #1;
  endtask

  task automatic drive(input logic [1:0] tr, input logic [31:0] a, input logic [31:0] d,
                       input logic w);
    htrans = tr;
    haddr  = a;
    hwdata = d;
    hwrite = w;
  endtask

  // Setup-phase snapshot: penable=0, hreadyout=0, plus address/select/direction.
  task automatic chk_setup(input string tag, input logic [31:0] a, input logic [2:0] sel,
                           input logic w);
    check({tag, ".paddr"}, paddr, a);
    check({tag, ".pselx"}, {29'd0, pselx}, {29'd0, sel});
    check({tag, ".pwrite"}, {31'd0, pwrite}, {31'd0, w});
    check({tag, ".penable"}, {31'd0, penable}, 32'd0);
    check({tag, ".hreadyout"}, {31'd0, hreadyout}, 32'd0);
  endtask

  task automatic chk_access(input string tag, input logic [31:0] a, input logic [2:0] sel);
    check({tag, ".paddr"}, paddr, a);
    check({tag, ".pselx"}, {29'd0, pselx}, {29'd0, sel});
    check({tag, ".penable"}, {31'd0, penable}, 32'd1);
    check({tag, ".hreadyout"}, {31'd0, hreadyout}, 32'd1);
  endtask

  task automatic chk_idle(input string tag);
    check({tag, ".pselx"}, {29'd0, pselx}, 32'd0);
    check({tag, ".penable"}, {31'd0, penable}, 32'd0);
    check({tag, ".hreadyout"}, {31'd0, hreadyout}, 32'd1);
  endtask

  // A read that must be ignored: a wrongly accepted read would be in READ
  // right after the edge with hreadyout low and a select asserted.
  task automatic ignored_read(input string tag, input logic [1:0] tr, input logic [31:0] a,
                              input logic rdy);
    hreadyin = rdy;
    drive(tr, a, 32'd0, 1'b0);
    tick;
    chk_idle(tag);
    hreadyin = 1'b1;
    drive(2'b00, a, 32'd0, 1'b0);
    tick;
    chk_idle({tag, "+1"});
  endtask

  // A single read that must be accepted, with the expected select.
  task automatic good_read(input string tag, input logic [31:0] a, input logic [2:0] sel,
                           input logic [31:0] rd);
    prdata = rd;
    drive(2'b10, a, 32'd0, 1'b0);
    tick;
    chk_setup({tag, ".rd"}, a, sel, 1'b0);
    drive(2'b00, a, 32'd0, 1'b0);
    tick;
    chk_access({tag, ".ren"}, a, sel);
    check({tag, ".hrdata"}, hrdata, rd);
    tick;
    chk_idle({tag, ".end"});
  endtask

  localparam logic [31:0] BA = 32'h8800_0000;
  localparam logic [31:0] BD = 32'hD000_0000;

  initial begin
    hresetn  = 1'b1;
    hreadyin = 1'b1;
    prdata   = 32'd0;
    drive(2'b00, 32'd0, 32'd0, 1'b0);

    // ---- reset for one cycle
    tick;
    chk_idle("rst");
    check("rst.paddr", paddr, 32'd0);
    check("rst.pwdata", pwdata, 32'd0);
    check("rst.pwrite", {31'd0, pwrite}, 32'd0);
    check("rst.hresp", {30'd0, hresp}, 32'd0);
    hresetn = 1'b0;
    tick;
    chk_idle("rst.rel");

    // ---- single write
    drive(2'b10, 32'h8000_0010, 32'd0, 1'b1);
    tick;
    chk_idle("sw.wwait");
    drive(2'b00, 32'h8000_0010, 32'hA5A5_A5A5, 1'b1);
    tick;
    chk_setup("sw.write", 32'h8000_0010, 3'b001, 1'b1);
    check("sw.write.pwdata", pwdata, 32'hA5A5_A5A5);
    tick;
    chk_access("sw.wen", 32'h8000_0010, 3'b001);
    check("sw.wen.pwdata", pwdata, 32'hA5A5_A5A5);
    check("sw.wen.pwrite", {31'd0, pwrite}, 32'd1);
    tick;
    chk_idle("sw.end");

    // ---- single read
    good_read("sr", 32'h8400_0004, 3'b010, 32'h1234_5678);

    // ---- 4-beat write burst; master holds its phase while hreadyout is low
    drive(2'b10, BA, 32'd0, 1'b1);
    tick;
    chk_idle("bw.wwait");
    drive(2'b11, BA + 4, BD + 0, 1'b1);
    tick;
    chk_setup("bw.b0", BA, 3'b100, 1'b1);
    check("bw.b0.pwdata", pwdata, BD + 0);
    drive(2'b11, BA + 8, BD + 1, 1'b1);
    tick;
    chk_access("bw.b0en", BA, 3'b100);
    tick;
    chk_setup("bw.b1", BA + 4, 3'b100, 1'b1);
    check("bw.b1.pwdata", pwdata, BD + 1);
    drive(2'b11, BA + 12, BD + 2, 1'b1);
    tick;
    chk_access("bw.b1en", BA + 4, 3'b100);
    tick;
    chk_setup("bw.b2", BA + 8, 3'b100, 1'b1);
    check("bw.b2.pwdata", pwdata, BD + 2);
    drive(2'b00, BA + 12, BD + 3, 1'b1);
    tick;
    chk_access("bw.b2en", BA + 8, 3'b100);
    tick;
    chk_setup("bw.b3", BA + 12, 3'b100, 1'b1);
    check("bw.b3.pwdata", pwdata, BD + 3);
    tick;
    chk_access("bw.b3en", BA + 12, 3'b100);
    tick;
    chk_idle("bw.end");

    // ---- ignored transfers
    ignored_read("ig.busy", 2'b01, 32'h8000_0000, 1'b1);
    ignored_read("ig.range", 2'b10, 32'h9000_0000, 1'b1);
    ignored_read("ig.edge", 2'b10, 32'h8C00_0000, 1'b1);
    ignored_read("ig.low", 2'b10, 32'h7FFF_FFFC, 1'b1);
    ignored_read("ig.nrdy", 2'b10, 32'h8000_0000, 1'b0);

    // ---- decode boundaries
    good_read("bd.s0top", 32'h83FF_FFFC, 3'b001, 32'h0000_0001);
    good_read("bd.s1bot", 32'h8400_0000, 3'b010, 32'h0000_0002);
    good_read("bd.s2top", 32'h8BFF_FFFC, 3'b100, 32'h0000_0003);

    // ---- write immediately followed by read
    prdata = 32'hDEAD_BEEF;
    drive(2'b10, 32'h8000_0020, 32'd0, 1'b1);
    tick;
    chk_idle("wr.wwait");
    drive(2'b10, 32'h8400_0008, 32'hCAFE_F00D, 1'b0);
    tick;
    chk_setup("wr.writep", 32'h8000_0020, 3'b001, 1'b1);
    check("wr.writep.pwdata", pwdata, 32'hCAFE_F00D);
    drive(2'b00, 32'h8400_0008, 32'd0, 1'b0);
    tick;
    chk_access("wr.wenp", 32'h8000_0020, 3'b001);
    tick;
    chk_setup("wr.read", 32'h8400_0008, 3'b010, 1'b0);
    tick;
    chk_access("wr.ren", 32'h8400_0008, 3'b010);
    check("wr.hrdata", hrdata, 32'hDEAD_BEEF);
    tick;
    chk_idle("wr.end");

    // ---- reset in the middle of a write
    drive(2'b10, 32'h8800_0040, 32'd0, 1'b1);
    tick;
    drive(2'b00, 32'h8800_0040, 32'h5555_AAAA, 1'b1);
    tick;
    chk_setup("mr.write", 32'h8800_0040, 3'b100, 1'b1);
    hresetn = 1'b1;
    tick;
    chk_idle("mr.rst");
    check("mr.paddr", paddr, 32'd0);
    check("mr.pwdata", pwdata, 32'd0);
    check("mr.pwrite", {31'd0, pwrite}, 32'd0);
    hresetn = 1'b0;
    tick;
    chk_idle("mr.after");
    check("mr.hresp", {30'd0, hresp}, 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
